// File: rtl/gate_delay_pkg.sv
// Shared types and default constants for the gate delay meter.
package gate_delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

  localparam int CNT_W_DEF         = 8;
  localparam int STABLE_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF       = 200;

endpackage

// File: rtl/gate_delay_meter.sv
// Measures settling delay, edge count and no-response of one network output
// after a start pulse.
//   state   | meaning
//   IDLE    | waiting for start, results held
//   MEASURE | counting elapsed cycles, edges and quiet cycles
//   REPORT  | done pulse, then back to IDLE
module gate_delay_meter
  import gate_delay_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay_cyc,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             glitch,
  output logic             no_change
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] quiet_q, quiet_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             glitch_q, glitch_d;
  logic             no_change_q, no_change_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    elapsed_d   = elapsed_q;
    quiet_d     = quiet_q;
    edge_cnt_d  = edge_cnt_q;
    delay_d     = delay_q;
    glitch_d    = glitch_q;
    no_change_d = no_change_q;

    case (state_q)
      ST_IDLE, ST_MEASURE: begin
        if (start) begin
          // A start while measuring restarts from the current sig_in.
          state_d     = ST_MEASURE;
          prev_d      = sig_in;
          elapsed_d   = '0;
          quiet_d     = '0;
          edge_cnt_d  = '0;
          delay_d     = '0;
          glitch_d    = 1'b0;
          no_change_d = 1'b0;
        end else if (state_q == ST_MEASURE) begin
          elapsed_d = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + CNT_ONE;
          if (sig_in != prev_q) begin
            edge_cnt_d = (edge_cnt_q == CNT_MAX) ? edge_cnt_q : edge_cnt_q + CNT_ONE;
            delay_d    = elapsed_d;
            quiet_d    = '0;
            prev_d     = sig_in;
          end else begin
            quiet_d = (quiet_q == CNT_MAX) ? quiet_q : quiet_q + CNT_ONE;
          end
          glitch_d = (edge_cnt_d > CNT_ONE);
          if ((edge_cnt_d != '0) && (quiet_d == STABLE_C)) begin
            state_d = ST_REPORT;
          end else if ((edge_cnt_d == '0) && (elapsed_d == TIMEOUT_C)) begin
            state_d     = ST_REPORT;
            no_change_d = 1'b1;
          end
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_MEASURE);
    done_d = (state_q == ST_MEASURE) && (state_d == ST_REPORT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prev_q      <= 1'b0;
      elapsed_q   <= '0;
      quiet_q     <= '0;
      edge_cnt_q  <= '0;
      delay_q     <= '0;
      glitch_q    <= 1'b0;
      no_change_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      elapsed_q   <= elapsed_d;
      quiet_q     <= quiet_d;
      edge_cnt_q  <= edge_cnt_d;
      delay_q     <= delay_d;
      glitch_q    <= glitch_d;
      no_change_q <= no_change_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign delay_cyc = delay_q;
  assign edge_cnt  = edge_cnt_q;
  assign glitch    = glitch_q;
  assign no_change = no_change_q;

endmodule

// File: tb/tb_gate_delay_meter.sv
// Scoreboard bench for gate_delay_meter: stimulus pushes expected reports,
// a negedge monitor pops and compares whenever done is seen.
module tb_gate_delay_meter;

  localparam int CNT_W   = 8;
  localparam int STABLE  = 4;
  localparam int TMO     = 20;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam int WMAX    = 400;

  typedef struct {
    int     delay;
    int     edges;
    int     glitch;
    int     nochg;
    longint cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sig_in = 1'b0;
  logic             busy, done, glitch, no_change;
  logic [CNT_W-1:0] delay_cyc, edge_cnt;

  gate_delay_meter #(.CNT_W(CNT_W), .STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_in(sig_in),
    .busy(busy), .done(done), .delay_cyc(delay_cyc), .edge_cnt(edge_cnt),
    .glitch(glitch), .no_change(no_change)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  bit   wave [0:WMAX-1];
  bit   tog  [0:WMAX-1];

  task automatic check(input string name, input longint act, input longint want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: list the edges, pick the first edge followed by a long enough
  // quiet gap, or report no-change if nothing moved by the timeout.
  function automatic exp_t model(output int kd);
    int   pos[$];
    int   sel;
    exp_t e;
    for (int k = 1; k < WMAX; k++) if (wave[k] != wave[k-1]) pos.push_back(k);
    e.cyc = 0;
    if (pos.size() == 0 || pos[0] > TMO) begin
      kd = TMO; e.delay = 0; e.edges = 0; e.glitch = 0; e.nochg = 1;
      return e;
    end
    sel = pos.size() - 1;
    for (int i = 0; i < pos.size() - 1; i++)
      if (pos[i+1] > pos[i] + STABLE) begin sel = i; break; end
    kd      = pos[sel] + STABLE;
    e.edges = (sel + 1 > MAXC) ? MAXC : sel + 1;
    e.delay = (pos[sel] > MAXC) ? MAXC : pos[sel];
    e.glitch = (e.edges > 1) ? 1 : 0;
    e.nochg  = 0;
    return e;
  endfunction

  function automatic void build_wave(input bit v0);
    wave[0] = v0;
    for (int k = 1; k < WMAX; k++) wave[k] = wave[k-1] ^ tog[k];
  endfunction

  function automatic void clear_tog();
    for (int k = 0; k < WMAX; k++) tog[k] = 1'b0;
  endfunction

  task automatic run_txn(input bit start_in_report);
    int   kd;
    exp_t e;
    e = model(kd);
    @(negedge clk);
    e.cyc = cyc + kd + 1;
    exp_q.push_back(e);
    start = 1'b1; sig_in = wave[0];
    for (int k = 1; k <= kd; k++) begin
      @(negedge clk);
      start = 1'b0; sig_in = wave[k];
      if (k == 1) check("busy_rise", busy, 1);
    end
    @(negedge clk);
    check("busy_fall_at_done", busy, 0);
    if (start_in_report) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_report", busy, 0);
  endtask

  task automatic run_random(input bit start_in_report);
    int p;
    int n;
    clear_tog();
    n = $urandom_range(0, 5);
    p = $urandom_range(1, 24);
    for (int i = 0; i < n; i++) begin
      tog[p] = 1'b1;
      p += $urandom_range(1, 6);
    end
    build_wave(1'($urandom_range(0, 1)));
    run_txn(start_in_report);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("delay_cyc", delay_cyc, e.delay);
        check("edge_cnt", edge_cnt, e.edges);
        check("glitch", glitch, e.glitch);
        check("no_change", no_change, e.nochg);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_delay"}, delay_cyc, 0);
    check({tag, "_edges"}, edge_cnt, 0);
    check({tag, "_glitch"}, glitch, 0);
    check({tag, "_nochg"}, no_change, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("reset");

    // Single transition at elapsed 3.
    clear_tog(); tog[3] = 1'b1; build_wave(1'b0); run_txn(1'b0);
    // Hazard: edges at 2 and 5.
    clear_tog(); tog[2] = 1'b1; tog[5] = 1'b1; build_wave(1'b0); run_txn(1'b0);
    // No response: timeout.
    clear_tog(); build_wave(1'b1); run_txn(1'b1);
    // Edge exactly at the timeout boundary still counts as a response.
    clear_tog(); tog[TMO] = 1'b1; build_wave(1'b0); run_txn(1'b0);
    // Gap of exactly STABLE keeps the measurement open.
    clear_tog(); tog[1] = 1'b1; tog[1+STABLE] = 1'b1; build_wave(1'b0); run_txn(1'b0);

    // Restart: edge at 2, restart at elapsed 4, then edge 3 cycles later.
    @(negedge clk); start = 1'b1; sig_in = 1'b0;
    @(negedge clk); start = 1'b0; sig_in = 1'b0;
    @(negedge clk); sig_in = 1'b1;
    @(negedge clk); sig_in = 1'b1;
    clear_tog(); tog[3] = 1'b1; build_wave(1'b1); run_txn(1'b0);

    // Reset mid-measurement: no done, outputs cleared.
    @(negedge clk); start = 1'b1; sig_in = 1'b0;
    @(negedge clk); start = 1'b0; sig_in = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_all_zero("midreset");
    repeat (30) @(negedge clk);
    check("midreset_idle_busy", busy, 0);
    clear_tog(); tog[4] = 1'b1; build_wave(1'b0); run_txn(1'b0);

    // Saturation: toggling every cycle for 300 cycles.
    clear_tog();
    for (int k = 1; k <= 300; k++) tog[k] = 1'b1;
    build_wave(1'b0); run_txn(1'b0);

    // Random transactions, some preceded by an aborted partial measurement.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); start = 1'b1; sig_in = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk); start = 1'b0; sig_in = 1'($urandom_range(0, 1));
        end
      end
      run_random(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
